// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of an in-order pipeline. Issues one instruction
// memory request at a time, tracks it with a three-state FSM, and delivers
// fetched words into the IF/ID pipeline register (InstrD/PCD/PCPlus4D/ValidD).
// A one-entry skid buffer catches a response that lands while decode is
// stalled, so the memory never has to be asked twice for the same word.
// Redirects (taken branch / jump) flush IF/ID and the skid buffer, realign the
// PC to a word boundary, and drop the response of any fetch already in flight.
//
// Ports
//   clk         in   1      rising-edge clock for all state
//   reset       in   1      synchronous, active-high reset
//   Stall       in   1      decode hazard; hold IF/ID
//   Redirect    in   1      taken branch/jump; flush and refetch
//   RedirectPC  in   WIDTH  redirect target (low two bits ignored)
//   IMemReq     out  1      fetch request strobe, one cycle per request
//   IMemAddr    out  WIDTH  fetch address, meaningful while IMemReq=1
//   IMemRvalid  in   1      response strobe
//   IMemRdata   in   WIDTH  instruction word, valid with IMemRvalid
//   InstrD      out  WIDTH  IF/ID instruction
//   PCD         out  WIDTH  PC of InstrD
//   PCPlus4D    out  WIDTH  PCD + 4
//   ValidD      out  1      1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] RedirectPC,
    output logic             IMemReq,
    output logic [WIDTH-1:0] IMemAddr,
    input  logic             IMemRvalid,
    input  logic [WIDTH-1:0] IMemRdata,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);

    // Canonical NOP (addi x0, x0, 0) used for bubbles.
    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(32'd4);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,  // free to issue a request
        S_WAIT    = 2'd1,  // request outstanding, response wanted
        S_DISCARD = 2'd2   // request outstanding, response to be dropped
    } fetch_state_e;

    fetch_state_e     state_q,     state_d;
    logic [WIDTH-1:0] pc_q,        pc_d;
    logic             buf_valid_q, buf_valid_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [WIDTH-1:0] buf_pc_q,    buf_pc_d;
    logic [WIDTH-1:0] instr_q,     instr_d;
    logic [WIDTH-1:0] pcd_q,       pcd_d;
    logic [WIDTH-1:0] pcp4_q,      pcp4_d;
    logic             valid_q,     valid_d;

    logic             req_fire_s;
    logic             rsp_take_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] buf_pc_plus4_s;
    logic [WIDTH-1:0] redirect_pc_s;

    // Request strobe and helper terms. The request is a decode of registered
    // state; it is forced low while reset is held so nothing leaves the block
    // during reset.
    always_comb begin
        req_fire_s     = (state_q == S_REQ) && !buf_valid_q && !reset;
        rsp_take_s     = (state_q == S_WAIT) && IMemRvalid;
        pc_plus4_s     = pc_q + PC_STEP;
        buf_pc_plus4_s = buf_pc_q + PC_STEP;
        redirect_pc_s  = {RedirectPC[WIDTH-1:2], 2'b00};
        IMemReq        = req_fire_s;
        IMemAddr       = pc_q;
    end

    // Next-state logic for the FSM, PC, skid buffer and IF/ID register.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;

        // FSM and PC advance for the normal (non-redirect) flow.
        case (state_q)
            S_REQ: begin
                // A response seen here has no matching request and is ignored.
                if (req_fire_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (IMemRvalid) begin
                    state_d = S_REQ;
                    if (!Redirect) begin
                        pc_d = pc_plus4_s;
                        if (Stall) begin
                            // Decode cannot take the word; park it.
                            buf_valid_d = 1'b1;
                            buf_instr_d = IMemRdata;
                            buf_pc_d    = pc_q;
                        end else begin
                            buf_valid_d = buf_valid_q;
                        end
                    end else begin
                        pc_d = pc_q;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (IMemRvalid) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides the flow above. A fetch still in flight (waiting,
        // being discarded, or issuing this cycle) must have its response
        // dropped. If that response arrives in this very cycle it has already
        // been consumed and dropped, so nothing remains outstanding and the
        // FSM can go straight back to issuing.
        if (Redirect) begin
            pc_d        = redirect_pc_s;
            buf_valid_d = 1'b0;
            if (req_fire_s ||
                (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !IMemRvalid)) begin
                state_d = S_DISCARD;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            pc_d = pc_d;
        end

        // IF/ID register: redirect bubble > stall hold > fresh response >
        // skid buffer > bubble. Bubbles keep PCD/PCPlus4D so the decode side
        // still sees the PC of the last real instruction.
        if (Redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (Stall) begin
            instr_d = instr_q;
            pcd_d   = pcd_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
        end else if (rsp_take_s) begin
            instr_d = IMemRdata;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4_s;
            valid_d = 1'b1;
        end else if (buf_valid_q) begin
            instr_d     = buf_instr_q;
            pcd_d       = buf_pc_q;
            pcp4_d      = buf_pc_plus4_s;
            valid_d     = 1'b1;
            buf_valid_d = 1'b0;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= {WIDTH{1'b0}};
            instr_q     <= NOP_INSTR;
            pcd_q       <= {WIDTH{1'b0}};
            pcp4_q      <= {WIDTH{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed cycle-by-cycle bench for if_fetch_stage. Each cycle the bench
// drives the inputs shortly after the rising edge, checks the combinational
// request outputs for that cycle, then steps one edge and checks IF/ID.
// Memory responses are driven by hand; a fetched word is its address XOR
// 32'hC0DE_0000, written out as literals below.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRvalid;
    logic [31:0] IMemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemRvalid (IMemRvalid),
        .IMemRdata  (IMemRdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] pcp4, input logic valid);
        chk_eq({tag, ".instr"}, InstrD, instr);
        chk_eq({tag, ".pcd"}, PCD, pc);
        chk_eq({tag, ".pcp4"}, PCPlus4D, pcp4);
        chk_eq({tag, ".valid"}, {31'd0, ValidD}, {31'd0, valid});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk_eq({tag, ".req"}, {31'd0, IMemReq}, {31'd0, req});
        if (req) begin
            chk_eq({tag, ".addr"}, IMemAddr, addr);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic v, input logic [31:0] d);
        Stall      = s;
        Redirect   = r;
        RedirectPC = rpc;
        IMemRvalid = v;
        IMemRdata  = d;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_req({tag, ".inrst"}, 1'b0, 32'h0);
        adv();
        chk_ifid(tag, NOP, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        adv();
        do_reset("rst0");

        // Streaming with one-cycle memory latency.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("s_r0", 1'b1, 32'h0);
        adv();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000); chk_req("s_w0", 1'b0, 32'h0);
        adv();                                          chk_ifid("s_i0", 32'hC0DE_0000, 32'h0, 32'h4, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("s_r4", 1'b1, 32'h4);
        adv();                                          chk_ifid("s_b0", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0004);
        adv();                                          chk_ifid("s_i4", 32'hC0DE_0004, 32'h4, 32'h8, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("s_r8", 1'b1, 32'h8);
        adv();                                          chk_ifid("s_b4", NOP, 32'h4, 32'h8, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0008);
        adv();                                          chk_ifid("s_i8", 32'hC0DE_0008, 32'h8, 32'hC, 1'b1);

        do_reset("rst1");

        // Stall during the response for address 4, released after 3 cycles.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("t_r0", 1'b1, 32'h0);
        adv();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000);
        adv();                                          chk_ifid("t_i0", 32'hC0DE_0000, 32'h0, 32'h4, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("t_r4", 1'b1, 32'h4);
        adv();                                          chk_ifid("t_b0", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE_0004); chk_req("t_st0", 1'b0, 32'h0);
        adv();                                          chk_ifid("t_h0", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("t_st1", 1'b0, 32'h0);
        adv();                                          chk_ifid("t_h1", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("t_st2", 1'b0, 32'h0);
        adv();                                          chk_ifid("t_h2", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("t_rel", 1'b0, 32'h0);
        adv();                                          chk_ifid("t_i4", 32'hC0DE_0004, 32'h4, 32'h8, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("t_r8", 1'b1, 32'h8);
        adv();                                          chk_ifid("t_b4", NOP, 32'h4, 32'h8, 1'b0);

        // Redirect to 0x100 while waiting for address 8; response for 8 dropped.
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);       chk_req("d_rd", 1'b0, 32'h0);
        adv();                                          chk_ifid("d_b", NOP, 32'h4, 32'h8, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0008); chk_req("d_drop", 1'b0, 32'h0);
        adv();                                          chk_ifid("d_dropped", NOP, 32'h4, 32'h8, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("d_r100", 1'b1, 32'h100);
        adv();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0100);
        adv();                                          chk_ifid("d_i100", 32'hC0DE_0100, 32'h100, 32'h104, 1'b1);

        // Redirect together with Stall, unaligned target 0x203.
        drive(1'b1, 1'b1, 32'h203, 1'b0, 32'h0);       chk_req("p_r104", 1'b1, 32'h104);
        adv();                                          chk_ifid("p_b", NOP, 32'h100, 32'h104, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0104); chk_req("p_drop", 1'b0, 32'h0);
        adv();                                          chk_ifid("p_dropped", NOP, 32'h100, 32'h104, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("p_r200", 1'b1, 32'h200);
        adv();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0200);
        adv();                                          chk_ifid("p_i200", 32'hC0DE_0200, 32'h200, 32'h204, 1'b1);

        // Reset while a request is outstanding; the late response is ignored.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("m_r204", 1'b1, 32'h204);
        adv();
        do_reset("m_rst");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0204); chk_req("m_first", 1'b1, 32'h0);
        adv();                                          chk_ifid("m_ign", NOP, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000);
        adv();                                          chk_ifid("m_i0", 32'hC0DE_0000, 32'h0, 32'h4, 1'b1);

        // Redirect to the top word; PC wraps to zero.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); chk_req("w_r4", 1'b1, 32'h4);
        adv();                                          chk_ifid("w_b", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0004);
        adv();                                          chk_ifid("w_dropped", NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("w_rtop", 1'b1, 32'hFFFF_FFFC);
        adv();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3F21_FFFC);
        adv();                                          chk_ifid("w_itop", 32'h3F21_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         chk_req("w_r0", 1'b1, 32'h0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
